// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and controller.
// master = fetch unit side, slave = memory/controller side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halted;

    modport master (
        output imem_req, imem_addr,
        output instr, instr_pc, instr_valid, halted,
        input  imem_rdata, instr_ready,
        input  redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        input  instr, instr_pc, instr_valid, halted,
        output imem_rdata, instr_ready,
        output redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, 1-cycle sync imem read, prefetch FIFO
// Ports: clk, reset (async active-low), bus (instr_fetch_unit_if.master)
module instr_fetch_unit #(
    parameter int                 ADDR_W     = 8,
    parameter int                 INSTR_W    = 16,
    parameter int                 DEPTH      = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = '1
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_active;
    logic [ADDR_W-1:0]  r_fpc;
    logic [ADDR_W-1:0]  r_req_pc;
    logic               r_inflight;
    logic [INSTR_W-1:0] r_fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  r_fifo_pc    [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_valid;
    logic               w_pop;
    logic               w_redirect;
    logic               w_take_halt;
    logic               w_issue;
    logic               w_flush;
    logic               w_push;
    logic [INSTR_W-1:0] w_head_instr;
    logic [OCC_W-1:0]   w_occ;

    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid & bus.instr_ready;
    assign w_head_instr = r_fifo_instr[r_rd_ptr];

    // Occupancy the FIFO will see once the pending response lands,
    // net of the head leaving this cycle.
    assign w_occ = OCC_W'(r_count) + OCC_W'(r_inflight)
                 - OCC_W'(w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_redirect  = 1'b0;
        w_take_halt = 1'b0;
        w_issue     = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_redirect  = bus.redirect;
                w_take_halt = w_pop & ~bus.redirect
                            & (w_head_instr == HALT_INSTR);
                // r_active holds off the first request for one
                // cycle so imem_req is low out of reset.
                w_issue     = r_active & ~bus.redirect
                            & (w_occ < OCC_W'(DEPTH));
                if (w_take_halt) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
        endcase
    end

    assign w_flush = w_redirect | w_take_halt;
    assign w_push  = r_inflight & ~w_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active   <= 1'b0;
            r_fpc      <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_active   <= 1'b1;
            r_inflight <= w_issue & ~w_take_halt;
            if (w_redirect) begin
                r_fpc <= bus.redirect_pc;
            end else if (w_issue) begin
                r_fpc <= r_fpc + ADDR_W'(1);
            end
            if (w_issue) begin
                r_req_pc <= r_fpc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
                r_fifo_pc[r_wr_ptr]    <= r_req_pc;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign bus.imem_req    = w_issue;
    assign bus.imem_addr   = r_fpc;
    assign bus.instr       = w_head_instr;
    assign bus.instr_pc    = r_fifo_pc[r_rd_ptr];
    assign bus.instr_valid = w_valid;
    assign bus.halted      = (r_state == S_HALT);

    ap_no_overflow: assert property (
        @(posedge clk) disable iff (!reset)
        !(w_push && !w_pop && (r_count == CNT_W'(DEPTH)))
    );

endmodule
